fib_gen: RTL and testbench
==========================

# fib_gen

Parametrised Fibonacci-class sequence generator, successor to the fixed 8-bit `fibonacci` PMOD demo. It has configurable width, an internal rate prescaler, run-time seeds (Fibonacci, Lucas or any 2-term recurrence), run/stop/single-step control, term index and overflow reporting. It sits under `chip`: buttons/DIP drive control, `value` drives PMOD LEDs.

## Interface
- `WIDTH`, 8, term width in bits (≥2)
- `DIV`, 50_000_000, clk cycles per advance in RUN (≥1)
- `IDX_W`, 8, width of term index counter
- `clk`  in  1  system clock (100 MHz)
- `rst`  in  1  reset, asynchronous, active-high
- `load`  in  1  pulse: latch `seed0`/`seed1`, restart sequence, go IDLE
- `start`  in  1  pulse: IDLE → RUN
- `stop`  in  1  pulse: RUN → IDLE
- `step`  in  1  pulse: single advance while IDLE
- `seed0`  in  WIDTH  first term, sampled on `load`
- `seed1`  in  WIDTH  second term, sampled on `load`
- `value`  out  WIDTH  current term
- `index`  out  IDX_W  advances since last restart, wraps modulo 2^IDX_W
- `upd`  out  1  one-cycle pulse, high in the cycle `value` changes
- `running`  out  1  high in RUN
- `ovf`  out  1  overflow indication (see Configuration)

## Operation
- Registers: `a` (= `value`), `b` (next term), `s0`/`s1` latched seeds, `last` flag, prescaler `cnt`, state.
- Reset: `a`=0, `b`=1, `s0`=0, `s1`=1, `last`=0, `cnt`=0, state IDLE, `index`=0, `upd`=0, `ovf`=0, `running`=0.
- States:
  - IDLE: `start` goes to RUN with `cnt`←0. `step` advances once.
  - RUN: `cnt` counts 0..DIV-1. At DIV-1 a tick fires, `cnt`←0 and the sequence advances. `stop` goes to IDLE.
  - HALT: exists only with the macro. Ignores `start`/`step`/`stop`. Only `load` or `rst` leaves it.
- Advance, normal: `a`←`b`, `b`←(`a`+`b`) mod 2^WIDTH, `index`+1. Compute the sum WIDTH+1 bits wide. If it carries, set `last`←1.
- `load` in any state: `s0`←`seed0`, `s1`←`seed1`, `a`←`seed0`, `b`←`seed1`, `index`←0, `last`←0, `ovf`←0, `cnt`←0, state IDLE, `upd`←1.
- Priority when inputs are simultaneous: `load` > `stop` > `start` > `step` > tick.
  - `start`+`step` in IDLE: enter RUN, no advance.
  - `stop` coinciding with a tick: IDLE, no advance.
- `step` while RUN: ignored. `start` while RUN: ignored. `cnt` is not reset.

## Timing
- Every action has 1-cycle latency: a control pulse or tick in cycle N produces register updates visible in N+1. `upd` is high in N+1 only.
- RUN cadence: the first advance occurs DIV cycles after `start`, then every DIV cycles.
- DIV=1: advance on every RUN cycle.
- `running` and `ovf` are registered, with no combinational input-to-output paths.
- Reset asserted mid-operation clears everything immediately, asynchronously. Deassertion is assumed synchronous to `clk` at `chip` level.

## Configuration
- Macro `FIB_HALT_ON_OVF_EN`.
- Without the macro, wrap behaviour applies:
  - An advance with `last`=1 restarts the sequence: `a`←`s0`, `b`←`s1`, `index`←0, `last`←0.
  - `ovf` pulses high for one cycle, aligned with `upd`.
  - The state is unchanged, so RUN continues.
- With the macro, halt behaviour applies:
  - An advance whose sum carries still performs `a`←`b`.
  - The state then goes to HALT and `ovf`←1, sticky until `load` or `rst`.
  - `last` is unused, and the unrepresentable term is never shown.

## Structure
- Package `fib_pkg`:
  - state enum (IDLE, RUN, HALT)
  - reset seed constants `FIB_RST_S0`=0 and `FIB_RST_S1`=1
- Sub-module `fib_tick`: the prescaler, with inputs `clk`, `rst`, `en`, `clr` and a one-cycle `tick` output, parameter `DIV`.
- `chip` mapping:
  - `value` → PMOD[55:48]
  - BUT[0] → `start`/`stop` toggle
  - BUT[1] → `load` from DIP
- Edge detection of the buttons stays in `chip`.

## Test plan
All scenarios use WIDTH=8 and DIV=4.
- Reset, then `start` → `value` sequence 1,1,2,3,5,8,13 with `upd` pulses exactly 4 cycles apart, the first 4 cycles after `start`. `index` reaches 7.
- `load` seeds 2,1 then `step`×5 in IDLE → `value` 2→1,3,4,7,11. `running`=0 throughout, one `upd` per step.
- No macro, from 0,1 in RUN:
  - 13th advance → `value`=233.
  - 14th advance → `value`=0, `ovf` high 1 cycle, `index`=0.
  - Following advances → 1,1,2…
- Macro set, same stimulus:
  - 13th advance → `value`=233, `ovf`=1, `running`=0.
  - 20 further ticks, `start` or `step` → no change.
  - `load` → `ovf`=0, IDLE.
- `stop` in the cycle of a tick → no advance, IDLE. `start`+`step` together in IDLE → RUN, `value` unchanged.
- `rst` asserted mid-RUN between clock edges → outputs at reset values before the next edge. `value`=0, `index`=0.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci-class sequence generator.
// Holds the controller state encoding and the reset seed values.
package fib_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fib_state_e;

    localparam int FIB_RST_S0 = 0;
    localparam int FIB_RST_S1 = 1;

endpackage

// File: rtl/fib_tick.sv
// Rate prescaler: counts 0..DIV-1 while enabled and fires a one-cycle tick
// on the last count, then wraps to 0.
// Ports: clk, rst (async, active-high), en (count enable),
//        clr (force count to 0, wins over en), tick (high on count DIV-1).
module fib_tick #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // Keep at least one bit so DIV=1 still builds a legal counter.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fib_gen.sv
// Fibonacci-class sequence generator with seeds, prescaled run mode,
// single step, term index and overflow report.
// Ports: clk, rst (async, active-high); load/start/stop/step pulses;
//        seed0/seed1 (sampled on load); value (current term), index
//        (advances since restart), upd (value-change pulse), running, ovf.
// Build option FIB_HALT_ON_OVF_EN: on carry, stop in HALT with sticky ovf
// instead of restarting from the latched seeds.
module fib_gen
    import fib_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 50_000_000,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    output logic [WIDTH-1:0] value,
    output logic [IDX_W-1:0] index,
    output logic             upd,
    output logic             running,
    output logic             ovf
);

    fib_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s0_q, s0_d;
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_q, last_d;
    logic             upd_q, upd_d;
    logic             ovf_q, ovf_d;
    logic             run_q;

    logic             run_en;
    logic             clr;
    logic             tick;
    logic             adv;
    logic [WIDTH:0]   sum;

    assign run_en = (state_q == ST_RUN);
    // One extra bit so the carry out of the term width is visible.
    assign sum    = {1'b0, a_q} + {1'b0, b_q};

    fib_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        idx_d   = idx_q;
        last_d  = last_q;
        upd_d   = 1'b0;
`ifdef FIB_HALT_ON_OVF_EN
        ovf_d   = ovf_q;
`else
        ovf_d   = 1'b0;
`endif
        clr     = 1'b0;
        adv     = 1'b0;

        if (load) begin
            s0_d    = seed0;
            s1_d    = seed1;
            a_d     = seed0;
            b_d     = seed1;
            idx_d   = '0;
            last_d  = 1'b0;
            ovf_d   = 1'b0;
            clr     = 1'b1;
            state_d = ST_IDLE;
            upd_d   = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // stop outranks start/step even though it is a no-op here
                    if (!stop) begin
                        if (start) begin
                            state_d = ST_RUN;
                            clr     = 1'b1;
                        end else if (step) begin
                            adv = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (tick) begin
                        adv = 1'b1;
                    end
                end
                ST_HALT: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (adv) begin
            upd_d = 1'b1;
`ifdef FIB_HALT_ON_OVF_EN
            a_d   = b_q;
            b_d   = sum[WIDTH-1:0];
            idx_d = idx_q + IDX_W'(1);
            if (sum[WIDTH]) begin
                state_d = ST_HALT;
                ovf_d   = 1'b1;
            end
`else
            // b already holds a wrapped term: restart instead of showing it
            if (last_q) begin
                a_d    = s0_q;
                b_d    = s1_q;
                idx_d  = '0;
                last_d = 1'b0;
                ovf_d  = 1'b1;
            end else begin
                a_d    = b_q;
                b_d    = sum[WIDTH-1:0];
                idx_d  = idx_q + IDX_W'(1);
                last_d = sum[WIDTH];
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= WIDTH'(FIB_RST_S0);
            b_q     <= WIDTH'(FIB_RST_S1);
            s0_q    <= WIDTH'(FIB_RST_S0);
            s1_q    <= WIDTH'(FIB_RST_S1);
            idx_q   <= '0;
            last_q  <= 1'b0;
            upd_q   <= 1'b0;
            ovf_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            upd_q   <= upd_d;
            ovf_q   <= ovf_d;
            run_q   <= (state_d == ST_RUN);
        end
    end

    assign value   = a_q;
    assign index   = idx_q;
    assign upd     = upd_q;
    assign running = run_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_fib_gen.sv
// Self-checking bench for fib_gen (WIDTH=8, DIV=4): directed scenarios
// plus random control pulses against a term-position reference model.
module tb_fib_gen;

    localparam int W   = 8;
    localparam int DIV = 4;
    localparam int IW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          step = 1'b0;
    logic [W-1:0]  seed0 = '0;
    logic [W-1:0]  seed1 = '0;
    logic [W-1:0]  value;
    logic [IW-1:0] index;
    logic          upd;
    logic          running;
    logic          ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the sequence is defined by its seeds and the
    // position n of the shown term; everything else follows arithmetically.
    int m_s0, m_s1, m_n, m_idx, m_cyc;
    bit m_run, m_halt, m_upd, m_ovf;

    fib_gen #(
        .WIDTH (W),
        .DIV   (DIV),
        .IDX_W (IW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .start   (start),
        .stop    (stop),
        .step    (step),
        .seed0   (seed0),
        .seed1   (seed1),
        .value   (value),
        .index   (index),
        .upd     (upd),
        .running (running),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Unbounded term n of the recurrence t(k+1) = t(k-1) + t(k).
    function automatic int term(input int s0, input int s1, input int n);
        int a = s0;
        int b = s1;
        int t;
        for (int k = 0; k < n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic model_reset();
        m_s0 = 0; m_s1 = 1; m_n = 0; m_idx = 0; m_cyc = 0;
        m_run = 0; m_halt = 0; m_upd = 0; m_ovf = 0;
    endtask

    task automatic model_advance();
        m_upd = 1;
`ifdef FIB_HALT_ON_OVF_EN
        m_n++;
        m_idx = (m_idx + 1) % (1 << IW);
        if (term(m_s0, m_s1, m_n + 1) >= (1 << W)) begin
            m_halt = 1;
            m_run  = 0;
            m_ovf  = 1;
        end
`else
        // The stored next term already exceeded the width: restart.
        if (term(m_s0, m_s1, m_n + 1) >= (1 << W)) begin
            m_n = 0;
            m_idx = 0;
            m_ovf = 1;
        end else begin
            m_n++;
            m_idx = (m_idx + 1) % (1 << IW);
        end
`endif
    endtask

    task automatic model_step(input bit l, input bit st, input bit sp,
                              input bit stp, input int v0, input int v1);
        m_upd = 0;
`ifndef FIB_HALT_ON_OVF_EN
        m_ovf = 0;
`endif
        if (l) begin
            m_s0 = v0; m_s1 = v1; m_n = 0; m_idx = 0; m_cyc = 0;
            m_run = 0; m_halt = 0; m_ovf = 0; m_upd = 1;
        end else if (m_halt) begin
        end else if (m_run) begin
            if (sp) begin
                m_run = 0;
            end else if (m_cyc == DIV - 1) begin
                m_cyc = 0;
                model_advance();
            end else begin
                m_cyc++;
            end
        end else if (!sp) begin
            if (st) begin
                m_run = 1;
                m_cyc = 0;
            end else if (stp) begin
                model_advance();
            end
        end
    endtask

    task automatic check_all();
        chk("value", 32'(value), 32'(term(m_s0, m_s1, m_n) % (1 << W)));
        chk("index", 32'(index), 32'(m_idx));
        chk("upd", 32'(upd), 32'(m_upd));
        chk("running", 32'(running), 32'(m_run));
        chk("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic drive(input bit l, input bit st, input bit sp,
                         input bit stp, input int v0, input int v1);
        @(negedge clk);
        load = l; start = st; stop = sp; step = stp;
        seed0 = W'(v0); seed1 = W'(v1);
        @(posedge clk);
        model_step(l, st, sp, stp, v0, v1);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Plain Fibonacci from reset in RUN.
        drive(0, 1, 0, 0, 0, 0);
        idle(7 * DIV);
        chk("fib_idx7", 32'(index), 32'd7);
        chk("fib_val13", 32'(value), 32'd13);
        drive(0, 0, 1, 0, 0, 0);

        // Lucas-like seeds stepped by hand.
        drive(1, 0, 0, 0, 2, 1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 0, 0);
            idle(2);
        end
        chk("step_val11", 32'(value), 32'd11);

        // Overflow handling from 0,1.
        drive(1, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0);
        idle(13 * DIV);
        chk("adv13_val", 32'(value), 32'd233);
        idle(DIV + 3 * DIV + 20);

        // stop landing on the tick cycle, then start+step together.
        drive(1, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0);
        idle(DIV - 1);
        drive(0, 0, 1, 0, 0, 0);
        chk("stop_tick_val", 32'(value), 32'd0);
        drive(0, 1, 0, 1, 0, 0);
        chk("start_step_val", 32'(value), 32'd0);
        idle(DIV + 1);
        drive(0, 0, 1, 0, 0, 0);

        // Random control traffic.
        for (int i = 0; i < 1500; i++) begin
            automatic bit l  = ($urandom_range(0, 59) == 0);
            automatic bit st = ($urandom_range(0, 7) == 0);
            automatic bit sp = ($urandom_range(0, 19) == 0);
            automatic bit sv = ($urandom_range(0, 5) == 0);
            automatic int v0 = ($urandom_range(0, 3) == 0) ? 0
                               : int'($urandom_range(0, 255));
            automatic int v1 = int'($urandom_range(0, 255));
            drive(l, st, sp, sv, v0, v1);
        end

        // Asynchronous reset in the middle of RUN.
        drive(1, 0, 0, 0, 3, 5);
        drive(0, 1, 0, 0, 0, 0);
        idle(3 * DIV + 2);
        #2;
        load = 0; start = 0; stop = 0; step = 0;
        rst = 1'b1;
        #1;
        chk("arst_value", 32'(value), 32'd0);
        chk("arst_index", 32'(index), 32'd0);
        chk("arst_running", 32'(running), 32'd0);
        chk("arst_upd", 32'(upd), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(0, 1, 0, 0, 0, 0);
        idle(3 * DIV);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
